// File: rtl/definitions_pkg.sv
// Shared widths, defaults and state types for the host side of the serial pixel link.
package definitions_pkg;

    localparam int FIFO_WIDTH           = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 16;
    localparam int FRAME_PIXELS_DEFAULT = 4096;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_RECOVER = 3'd4
    } rx_state_t;

    // The line carries data LSB first: the newest bit enters at the top, the oldest leaves at bit 0.
    function automatic logic [FIFO_WIDTH-1:0] shift_lsb_first(input logic [FIFO_WIDTH-1:0] word,
                                                              input logic                  bit_in);
        return {bit_in, word[FIFO_WIDTH-1:1]};
    endfunction

endpackage

// File: rtl/pixel_link_rx.sv
// Receive half of the pixel link: synchronizes the chip's tx line and recovers 8N1 bytes.
// byte_done / stop_err are single-cycle strobes; the top registers them onto its ports.
module pixel_link_rx
    import definitions_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chip_tx,
    output logic [FIFO_WIDTH-1:0] byte_data,
    output logic                  byte_done,
    output logic                  stop_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(FIFO_WIDTH);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(FIFO_WIDTH - 1);

    logic [1:0]            sync_r;
    logic                  line_s;
    rx_state_t             state_r, state_s;
    logic [CW-1:0]         cnt_r, cnt_s;
    logic [BW-1:0]         bit_r, bit_s;
    logic [FIFO_WIDTH-1:0] shift_r, shift_s;
    logic                  done_s, err_s;

    assign line_s = sync_r[1];

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], chip_tx};
        end
    end

    // RX state, sample counter, bit index and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RX_IDLE;
            cnt_r   <= CNT_ZERO;
            bit_r   <= {BW{1'b0}};
            shift_r <= {FIFO_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
        end
    end

    // Next-state logic: half a bit to reach mid-start, then a full bit between samples.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + CNT_ONE;
        bit_s   = bit_r;
        shift_s = shift_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            RX_IDLE: begin
                cnt_s = CNT_ZERO;
                if (!line_s) state_s = RX_START;
                else         state_s = RX_IDLE;
            end
            RX_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = CNT_ZERO;
                    bit_s = {BW{1'b0}};
                    if (!line_s) state_s = RX_DATA;
                    else         state_s = RX_IDLE;
                end else begin
                    state_s = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s   = CNT_ZERO;
                    shift_s = shift_lsb_first(shift_r, line_s);
                    if (bit_r == DATA_LAST) state_s = RX_STOP;
                    else                    bit_s   = bit_r + BW'(1'b1);
                end else begin
                    state_s = RX_DATA;
                end
            end
            RX_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is never missed.
                if (cnt_r == BIT_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (line_s) begin
                        done_s  = 1'b1;
                        state_s = RX_IDLE;
                    end else begin
                        err_s   = 1'b1;
                        state_s = RX_RECOVER;
                    end
                end else begin
                    state_s = RX_STOP;
                end
            end
            RX_RECOVER: begin
                cnt_s = CNT_ZERO;
                if (line_s) state_s = RX_IDLE;
                else        state_s = RX_RECOVER;
            end
            default: begin
                state_s = RX_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    assign byte_data = shift_r;
    assign byte_done = done_s;
    assign stop_err  = err_s;

endmodule

// File: rtl/pixel_link_host.sv
// Host endpoint of the serial pixel link: 8N1 transmitter toward the chip's rx pin,
// receiver for the chip's tx pin, and per-frame pixel counting in both directions.
module pixel_link_host
    import definitions_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FIFO_WIDTH-1:0]           pix_in,
    input  logic                            pix_in_valid,
    output logic                            pix_in_ready,
    output logic                            chip_rx,
    input  logic                            chip_tx,
    output logic [FIFO_WIDTH-1:0]           pix_out,
    output logic                            pix_out_valid,
    output logic                            frame_err,
    output logic                            tx_frame_done,
    output logic                            rx_frame_done,
    output logic [$clog2(FRAME_PIXELS)-1:0] rx_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(FIFO_WIDTH);
    localparam int FW = $clog2(FRAME_PIXELS);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(FIFO_WIDTH - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_PIXELS - 1);
    localparam logic [FW-1:0] FRAME_ZERO = {FW{1'b0}};

    tx_state_t             tx_state_r, tx_state_s;
    logic [CW-1:0]         tx_cnt_r, tx_cnt_s;
    logic [BW-1:0]         tx_bit_r, tx_bit_s;
    logic [FIFO_WIDTH-1:0] tx_shift_r, tx_shift_s;
    logic                  chip_rx_r, line_s;
    logic                  pix_in_ready_r, ready_s;
    logic                  accept_s;
    logic [FW-1:0]         tx_count_r;
    logic                  tx_frame_done_r;

    logic [FIFO_WIDTH-1:0] rx_byte_s;
    logic                  rx_done_s, rx_err_s;
    logic [FIFO_WIDTH-1:0] pix_out_r;
    logic                  pix_out_valid_r, frame_err_r, rx_frame_done_r;
    logic [FW-1:0]         rx_count_r;

    assign accept_s = pix_in_valid && pix_in_ready_r;

    // TX state and datapath registers; line and ready are registered from next-state values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r     <= TX_IDLE;
            tx_cnt_r       <= CNT_ZERO;
            tx_bit_r       <= {BW{1'b0}};
            tx_shift_r     <= {FIFO_WIDTH{1'b0}};
            chip_rx_r      <= 1'b1;
            pix_in_ready_r <= 1'b1;
        end else begin
            tx_state_r     <= tx_state_s;
            tx_cnt_r       <= tx_cnt_s;
            tx_bit_r       <= tx_bit_s;
            tx_shift_r     <= tx_shift_s;
            chip_rx_r      <= line_s;
            pix_in_ready_r <= ready_s;
        end
    end

    // TX next-state logic; an accept in the last stop cycle chains straight into the next start bit.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r + CNT_ONE;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        case (tx_state_r)
            TX_IDLE: begin
                tx_cnt_s = CNT_ZERO;
                if (accept_s) begin
                    tx_state_s = TX_START;
                    tx_shift_s = pix_in;
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_s = TX_DATA;
                    tx_cnt_s   = CNT_ZERO;
                    tx_bit_s   = {BW{1'b0}};
                end else begin
                    tx_state_s = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s   = CNT_ZERO;
                    tx_shift_s = shift_lsb_first(tx_shift_r, 1'b1);
                    if (tx_bit_r == DATA_LAST) tx_state_s = TX_STOP;
                    else                       tx_bit_s   = tx_bit_r + BW'(1'b1);
                end else begin
                    tx_state_s = TX_DATA;
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s = CNT_ZERO;
                    if (accept_s) begin
                        tx_state_s = TX_START;
                        tx_shift_s = pix_in;
                    end else begin
                        tx_state_s = TX_IDLE;
                    end
                end else begin
                    tx_state_s = TX_STOP;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
                tx_cnt_s   = CNT_ZERO;
            end
        endcase

        case (tx_state_s)
            TX_START: line_s = 1'b0;
            TX_DATA:  line_s = tx_shift_s[0];
            default:  line_s = 1'b1;
        endcase
        ready_s = (tx_state_s == TX_IDLE) || ((tx_state_s == TX_STOP) && (tx_cnt_s == BIT_LAST));
    end

    // TX frame counter; the done pulse follows the accept of the frame's last pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_count_r      <= FRAME_ZERO;
            tx_frame_done_r <= 1'b0;
        end else if (accept_s) begin
            if (tx_count_r == FRAME_LAST) begin
                tx_count_r      <= FRAME_ZERO;
                tx_frame_done_r <= 1'b1;
            end else begin
                tx_count_r      <= tx_count_r + FW'(1'b1);
                tx_frame_done_r <= 1'b0;
            end
        end else begin
            tx_frame_done_r <= 1'b0;
        end
    end

    pixel_link_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .chip_tx  (chip_tx),
        .byte_data(rx_byte_s),
        .byte_done(rx_done_s),
        .stop_err (rx_err_s)
    );

    // RX output registers and frame counter; pix_out holds between valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_out_r       <= {FIFO_WIDTH{1'b0}};
            pix_out_valid_r <= 1'b0;
            frame_err_r     <= 1'b0;
            rx_frame_done_r <= 1'b0;
            rx_count_r      <= FRAME_ZERO;
        end else begin
            pix_out_valid_r <= rx_done_s;
            frame_err_r     <= rx_err_s;
            if (rx_done_s) begin
                pix_out_r <= rx_byte_s;
                if (rx_count_r == FRAME_LAST) begin
                    rx_count_r      <= FRAME_ZERO;
                    rx_frame_done_r <= 1'b1;
                end else begin
                    rx_count_r      <= rx_count_r + FW'(1'b1);
                    rx_frame_done_r <= 1'b0;
                end
            end else begin
                rx_frame_done_r <= 1'b0;
            end
        end
    end

    assign chip_rx       = chip_rx_r;
    assign pix_in_ready  = pix_in_ready_r;
    assign pix_out       = pix_out_r;
    assign pix_out_valid = pix_out_valid_r;
    assign frame_err     = frame_err_r;
    assign tx_frame_done = tx_frame_done_r;
    assign rx_frame_done = rx_frame_done_r;
    assign rx_count      = rx_count_r;

endmodule

// File: tb/tb_pixel_link_host.sv
// Self-checking bench for pixel_link_host: random traffic against a frame-level reference model.
module tb_pixel_link_host;
    import definitions_pkg::*;

    localparam int C  = 16;
    localparam int FP = 4;
    localparam int FW = $clog2(FP);

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    pix_in;
    logic          pix_in_valid;
    logic          pix_in_ready;
    logic          chip_rx;
    logic          chip_tx_s;
    logic [7:0]    pix_out;
    logic          pix_out_valid;
    logic          frame_err;
    logic          tx_frame_done;
    logic          rx_frame_done;
    logic [FW-1:0] rx_count;

    logic loop_en;
    logic drv_tx;
    assign chip_tx_s = loop_en ? chip_rx : drv_tx;

    pixel_link_host #(.CLKS_PER_BIT(C), .FRAME_PIXELS(FP)) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_in       (pix_in),
        .pix_in_valid (pix_in_valid),
        .pix_in_ready (pix_in_ready),
        .chip_rx      (chip_rx),
        .chip_tx      (chip_tx_s),
        .pix_out      (pix_out),
        .pix_out_valid(pix_out_valid),
        .frame_err    (frame_err),
        .tx_frame_done(tx_frame_done),
        .rx_frame_done(rx_frame_done),
        .rx_count     (rx_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: expected received bytes with their arrival cycles, frame counters.
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    int         rx_model_cnt = 0;
    int         tx_model_cnt = 0;
    bit         tx_done_pend = 1'b0;
    int         err_seen = 0, valid_seen = 0, tx_done_seen = 0, rx_done_seen = 0;
    logic [7:0] last_rx = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Cycle counter and transmit-accept model (pre-edge values are seen here).
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst && pix_in_valid && pix_in_ready) begin
            tx_model_cnt++;
            tx_done_pend = (tx_model_cnt == FP);
            if (tx_model_cnt == FP) tx_model_cnt = 0;
        end else begin
            tx_done_pend = 1'b0;
        end
    end

    // Output monitor on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (pix_out_valid) begin
                valid_seen++;
                if (exp_q.size() == 0) begin
                    check_eq("rx_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    logic [7:0] b;
                    int         ec;
                    bit         fd;
                    b  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check_eq("rx_data", pix_out, b);
                    check_eq("rx_latency", cyc, ec);
                    rx_model_cnt++;
                    fd = (rx_model_cnt == FP);
                    if (fd) rx_model_cnt = 0;
                    check_eq("rx_frame_done", rx_frame_done, fd);
                    check_eq("rx_count", rx_count, rx_model_cnt);
                    last_rx = b;
                end
            end else if (rx_frame_done) begin
                check_eq("rx_done_without_valid", 32'd1, 32'd0);
            end
            if (frame_err) err_seen++;
            if (tx_frame_done) tx_done_seen++;
            if (rx_frame_done) rx_done_seen++;
            if (tx_frame_done || tx_done_pend) check_eq("tx_frame_done", tx_frame_done, tx_done_pend);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_chip_rx"}, chip_rx, 1'b1);
        check_eq({tag, "_ready"}, pix_in_ready, 1'b1);
        check_eq({tag, "_pix_out"}, pix_out, 8'h00);
        check_eq({tag, "_valid"}, pix_out_valid, 1'b0);
        check_eq({tag, "_frame_err"}, frame_err, 1'b0);
        check_eq({tag, "_tx_done"}, tx_frame_done, 1'b0);
        check_eq({tag, "_rx_done"}, rx_frame_done, 1'b0);
        check_eq({tag, "_rx_count"}, rx_count, 0);
    endtask

    // Asserts reset from the current point (mid-byte allowed) and restarts the model.
    task automatic do_reset(input int hold);
        rst = 1'b1;
        #1;
        check_reset_outputs("in_reset");
        exp_q.delete();
        exp_cyc_q.delete();
        rx_model_cnt = 0;
        tx_model_cnt = 0;
        tx_done_pend = 1'b0;
        last_rx      = 8'h00;
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Offers one byte; returns the first cycle after the accept (first start-bit cycle).
    task automatic send_byte(input logic [7:0] b, output int t1);
        int budget;
        budget = 0;
        while (!pix_in_ready && budget < 20 * C) begin
            tick(1);
            budget++;
        end
        if (!pix_in_ready) begin
            check_eq("tx_ready_timeout", 32'd0, 32'd1);
            t1 = cyc;
        end else begin
            pix_in       = b;
            pix_in_valid = 1'b1;
            @(posedge clk);
            #1;
            pix_in_valid = 1'b0;
            t1 = cyc;
            if (loop_en) begin
                exp_q.push_back(b);
                exp_cyc_q.push_back(t1 + 9 * C + C / 2 + 3);
            end
        end
    endtask

    // Bench-driven chip_tx frame with a chosen stop-bit level.
    task automatic drive_uart(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        if (stop_bit) begin
            exp_q.push_back(b);
            exp_cyc_q.push_back(cyc + 9 * C + C / 2 + 3);
        end
        for (int k = 0; k < 10; k++) begin
            drv_tx = fr[k];
            tick(C);
        end
        drv_tx = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30 * C) begin
            tick(1);
            n++;
        end
        check_eq("rx_drain", exp_q.size(), 0);
        tick(4);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         t1, tprev, e0, v0, c0, d0, r0, glen;
        logic [9:0] fr;
        logic [7:0] b;

        rst = 1'b0; pix_in = 8'h00; pix_in_valid = 1'b0; loop_en = 1'b0; drv_tx = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset");
        tick(3);
        rst = 1'b0;
        tick(2);
        check_reset_outputs("post_reset");

        // Single byte waveform: line level at the start and middle of each bit, ready window.
        fr = {1'b1, 8'hA5, 1'b0};
        send_byte(8'hA5, t1);
        for (int j = 0; j < 10 * C; j++) begin
            if ((j % C) == 0 || (j % C) == C / 2) check_eq($sformatf("tx_bit%0d", j / C), chip_rx, fr[j / C]);
            check_eq("tx_ready", pix_in_ready, (j == 10 * C - 1));
            tick(1);
        end
        check_eq("tx_idle_line", chip_rx, 1'b1);
        tick(C);

        // Loopback, back-to-back fixed bytes with exact 10C accept period.
        loop_en = 1'b1;
        e0 = err_seen;
        tick(2);
        send_byte(8'h00, tprev);
        send_byte(8'hFF, t1);
        check_eq("tx_period_1", t1 - tprev, 10 * C);
        tprev = t1;
        send_byte(8'h3C, t1);
        check_eq("tx_period_2", t1 - tprev, 10 * C);
        wait_drain();
        check_eq("loop_no_frame_err", err_seen, e0);
        check_eq("pix_out_hold", pix_out, 8'h3C);

        // Random loopback traffic with random idle gaps.
        for (int i = 0; i < 8; i++) begin
            send_byte(8'($urandom_range(0, 255)), t1);
            if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 3 * C));
        end
        wait_drain();
        check_eq("rand_no_frame_err", err_seen, e0);
        check_eq("rand_pix_out_hold", pix_out, last_rx);

        // Framing error, then a good byte.
        loop_en = 1'b0;
        tick(2 * C);
        e0 = err_seen; v0 = valid_seen; c0 = int'(rx_count);
        drive_uart(8'h55, 1'b0);
        tick(3 * C);
        check_eq("ferr_count", err_seen, e0 + 1);
        check_eq("ferr_no_valid", valid_seen, v0);
        check_eq("ferr_rx_count", rx_count, c0);
        drive_uart(8'h12, 1'b1);
        wait_drain();
        check_eq("ferr_then_good", valid_seen, v0 + 1);

        // Glitches shorter than half a bit are rejected; a good byte then decodes.
        for (int i = 0; i < 4; i++) begin
            glen = (i == 0) ? 4 : int'($urandom_range(1, C / 2 - 1));
            e0 = err_seen; v0 = valid_seen;
            drv_tx = 1'b0;
            tick(glen);
            drv_tx = 1'b1;
            tick(2 * C);
            check_eq($sformatf("glitch%0d_no_valid", glen), valid_seen, v0);
            check_eq($sformatf("glitch%0d_no_err", glen), err_seen, e0);
        end
        b = 8'($urandom_range(0, 255));
        drive_uart(b, 1'b1);
        wait_drain();

        // Frame wrap in both directions.
        do_reset(3);
        tick(2);
        loop_en = 1'b1;
        d0 = tx_done_seen; r0 = rx_done_seen;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), t1);
        wait_drain();
        check_eq("wrap_tx_done_count", tx_done_seen - d0, 1);
        check_eq("wrap_rx_done_count", rx_done_seen - r0, 1);
        check_eq("wrap_rx_count", rx_count, 1);

        // Reset in the middle of data bit 3, then a clean byte.
        send_byte(8'($urandom_range(0, 255)), t1);
        tick(4 * C + C / 2);
        v0 = valid_seen;
        do_reset(3);
        tick(12 * C);
        check_eq("rst_mid_no_valid", valid_seen, v0);
        send_byte(8'h81, t1);
        fr = {1'b1, 8'h81, 1'b0};
        for (int j = 0; j < 10 * C; j++) begin
            if ((j % C) == C / 2) check_eq($sformatf("rst_tx_bit%0d", j / C), chip_rx, fr[j / C]);
            tick(1);
        end
        wait_drain();
        check_eq("rst_then_81", pix_out, 8'h81);
        check_eq("rst_then_count", rx_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
